// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST engine.
// Holds FSM/phase enums, LFSR constants and the LFSR step function.
package adder_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK
   } state_t;

   typedef enum logic [1:0] {
      PH_DIRECTED,
      PH_WALK,
      PH_RANDOM
   } phase_t;

   localparam logic [15:0] LFSR_MASK    = 16'hB400;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;
   localparam int          NUM_DIRECTED = 8;

   // Right-shifting Galois step: feedback taps applied when lsb is 1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      lfsr_next = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Galois LFSR for random BIST vectors.
// Ports: clk, rst_n (sync, active-low), load (reseed), step (advance), q (state).
module bist_lfsr16
   import adder_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   output logic [15:0] q
);

   logic [15:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= LFSR_SEED;
      end else if (load) begin
         r_q <= LFSR_SEED;
      end else if (step) begin
         r_q <= lfsr_next(r_q);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/adder_bist_engine.sv
// BIST engine for combinational ripple adders: drives vectors, checks sum/cout.
// Ports: clk, rst_n, start in; dut_a/b/cin out; dut_sum/cout in; status out.
module adder_bist_engine
   import adder_bist_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SETTLE   = 1,
   parameter int NUM_RAND = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   output logic             dut_cin,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic             dut_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic             first_fail_valid,
   output logic [15:0]      first_fail_idx
);

   localparam int          N        = NUM_DIRECTED + WIDTH + NUM_RAND;
   localparam logic [15:0] LAST     = 16'(N - 1);
   localparam logic [15:0] SET_M1   = 16'(SETTLE - 1);
   localparam logic [15:0] DIR_END  = 16'(NUM_DIRECTED);
   localparam logic [15:0] WALK_END = 16'(NUM_DIRECTED + WIDTH);
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   phase_t           w_phase;
   logic [15:0]      r_cnt;
   logic [15:0]      r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cin;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [15:0]      r_err;
   logic             r_ffv;
   logic [15:0]      r_ffi;

   logic [15:0]      w_lfsr;
   logic             w_accept;
   logic             w_leave_chk;
   logic             w_last;
   logic [15:0]      w_vidx;
   logic [3:0]       w_k;
   logic [WIDTH-1:0] w_na;
   logic [WIDTH-1:0] w_nb;
   logic             w_ncin;
   logic [WIDTH:0]   w_exp;
   logic             w_mis;
   logic [15:0]      w_err_nxt;
   logic             w_step;

   assign w_accept    = (r_state == ST_IDLE) && start;
   assign w_leave_chk = (r_state == ST_CHECK);
   assign w_last      = (r_idx == LAST);

   // Index of the vector loaded on this edge: 0 on start, else the next one.
   assign w_vidx = w_accept ? 16'd0 : r_idx + 16'd1;
   assign w_k    = w_vidx[3:0] - 4'd8;

   always_comb begin
      if (w_vidx < DIR_END) begin
         w_phase = PH_DIRECTED;
      end else if (w_vidx < WALK_END) begin
         w_phase = PH_WALK;
      end else begin
         w_phase = PH_RANDOM;
      end
   end

   always_comb begin
      w_na   = '0;
      w_nb   = '0;
      w_ncin = 1'b0;
      unique case (w_phase)
         PH_DIRECTED: begin
            unique case (w_vidx[2:0])
               3'd0: ;
               3'd1: w_ncin = 1'b1;
               3'd2: w_na = ONES;
               3'd3: begin
                  w_na   = ONES;
                  w_ncin = 1'b1;
               end
               3'd4: begin
                  w_nb   = ONES;
                  w_ncin = 1'b1;
               end
               3'd5: begin
                  w_na = ONES;
                  w_nb = ONES;
               end
               3'd6: begin
                  w_na   = ONES;
                  w_nb   = ONES;
                  w_ncin = 1'b1;
               end
               3'd7: begin
                  w_na = MSB;
                  w_nb = MSB;
               end
               default: ;
            endcase
         end
         PH_WALK: begin
            w_na = ONE << w_k;
            w_nb = ONE << w_k;
         end
         PH_RANDOM: begin
            w_na   = w_lfsr[WIDTH-1:0];
            w_nb   = w_lfsr[15:16-WIDTH];
            w_ncin = w_lfsr[8];
         end
         default: ;
      endcase
   end

   // Random vectors use the current LFSR state, then advance it.
   assign w_step = w_leave_chk && !w_last && (w_phase == PH_RANDOM);

   bist_lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_accept),
      .step  (w_step),
      .q     (w_lfsr)
   );

   assign w_exp = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
   assign w_mis = (w_exp != {dut_cout, dut_sum});
   assign w_err_nxt = (w_mis && (r_err != 16'hFFFF)) ? r_err + 16'd1
                                                     : r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == SET_M1) begin
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_state_nxt = w_last ? ST_IDLE : ST_SETTLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_idx  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_cin  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_err  <= '0;
         r_ffv  <= 1'b0;
         r_ffi  <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_busy <= 1'b1;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_ffv  <= 1'b0;
            r_ffi  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_a    <= w_na;
            r_b    <= w_nb;
            r_cin  <= w_ncin;
         end else if (r_state == ST_SETTLE) begin
            r_cnt <= (r_cnt == SET_M1) ? 16'd0 : r_cnt + 16'd1;
         end else if (w_leave_chk) begin
            r_err <= w_err_nxt;
            if (w_mis && !r_ffv) begin
               r_ffv <= 1'b1;
               r_ffi <= r_idx;
            end
            if (w_last) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_pass <= (w_err_nxt == 16'd0);
            end else begin
               r_idx <= w_vidx;
               r_a   <= w_na;
               r_b   <= w_nb;
               r_cin <= w_ncin;
            end
         end
      end
   end

   assign dut_a            = r_a;
   assign dut_b            = r_b;
   assign dut_cin          = r_cin;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_valid = r_ffv;
   assign first_fail_idx   = r_ffi;

endmodule

// File: tb/tb_adder_bist_engine.sv
// Self-checking bench for adder_bist_engine with a faultable adder model.
// Expected vectors are queued at start and popped as the DUT drives them.
module tb_adder_bist_engine;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n   = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   int   mode    = 0;
   int   sel     = 0;
   int   total   = 0;
   int   bad     = 0;
   vec_t q[$];

   logic [7:0]  a_a, a_b, a_sum;
   logic        a_cin, a_cout, a_busy, a_done, a_pass, a_ffv;
   logic [15:0] a_err, a_ffi;
   logic [3:0]  b_a, b_b, b_sum;
   logic        b_cin, b_cout, b_busy, b_done, b_pass, b_ffv;
   logic [15:0] b_err, b_ffi;

   logic [7:0]  m_a, m_b;
   logic        m_cin, m_busy, m_done, m_pass, m_ffv;
   logic [15:0] m_err, m_ffi;

   function automatic logic [8:0] adder(input int w, input logic [7:0] x,
                                        input logic [7:0] y, input logic c,
                                        input int m);
      int full, s, co;
      full = int'(x) + int'(y) + int'(c);
      s    = full & ((1 << w) - 1);
      co   = (full >> w) & 1;
      if (m == 1) co = 0;
      if (m == 2) s = s ^ 1;
      return 9'((co << w) | s);
   endfunction

   logic [8:0] w_ra;
   logic [8:0] w_rb;
   assign w_ra = adder(8, a_a, a_b, a_cin, mode);
   assign w_rb = adder(4, {4'b0, b_a}, {4'b0, b_b}, b_cin, mode);
   assign {a_cout, a_sum} = w_ra;
   assign {b_cout, b_sum} = w_rb[4:0];

   adder_bist_engine u_dut_a (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_a),
      .dut_a            (a_a),
      .dut_b            (a_b),
      .dut_cin          (a_cin),
      .dut_sum          (a_sum),
      .dut_cout         (a_cout),
      .busy             (a_busy),
      .done             (a_done),
      .pass             (a_pass),
      .err_count        (a_err),
      .first_fail_valid (a_ffv),
      .first_fail_idx   (a_ffi)
   );

   adder_bist_engine #(
      .WIDTH    (4),
      .SETTLE   (2),
      .NUM_RAND (16)
   ) u_dut_b (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_b),
      .dut_a            (b_a),
      .dut_b            (b_b),
      .dut_cin          (b_cin),
      .dut_sum          (b_sum),
      .dut_cout         (b_cout),
      .busy             (b_busy),
      .done             (b_done),
      .pass             (b_pass),
      .err_count        (b_err),
      .first_fail_valid (b_ffv),
      .first_fail_idx   (b_ffi)
   );

   always_comb begin
      if (sel == 0) begin
         m_a = a_a; m_b = a_b; m_cin = a_cin;
         m_busy = a_busy; m_done = a_done; m_pass = a_pass;
         m_ffv = a_ffv; m_err = a_err; m_ffi = a_ffi;
      end else begin
         m_a = {4'b0, b_a}; m_b = {4'b0, b_b}; m_cin = b_cin;
         m_busy = b_busy; m_done = b_done; m_pass = b_pass;
         m_ffv = b_ffv; m_err = b_err; m_ffi = b_ffi;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference vector list and expected results for one run.
   task automatic gen_run(input int w, input int nr, input int m,
                          output int e_err, output int e_ffi,
                          output int e_ffv);
      logic [15:0] s;
      logic [7:0]  ones, msb;
      vec_t        v;
      int          n;
      logic [8:0]  good, got;
      s    = 16'hACE1;
      ones = 8'((1 << w) - 1);
      msb  = 8'(1 << (w - 1));
      n    = 8 + w + nr;
      e_err = 0; e_ffi = 0; e_ffv = 0;
      for (int i = 0; i < n; i++) begin
         v = '0;
         if (i < 8) begin
            case (i)
               1: v.cin = 1;
               2: v.a = ones;
               3: begin v.a = ones; v.cin = 1; end
               4: begin v.b = ones; v.cin = 1; end
               5: begin v.a = ones; v.b = ones; end
               6: begin v.a = ones; v.b = ones; v.cin = 1; end
               7: begin v.a = msb; v.b = msb; end
               default: ;
            endcase
         end else if (i < 8 + w) begin
            v.a = 8'(1 << (i - 8));
            v.b = v.a;
         end else begin
            v.a   = 8'(s & 16'(ones));
            v.b   = 8'(s >> (16 - w));
            v.cin = s[8];
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
         end
         q.push_back(v);
         good = 9'(int'(v.a) + int'(v.b) + int'(v.cin));
         got  = adder(w, v.a, v.b, v.cin, m);
         if (good != got) begin
            if (e_ffv == 0) e_ffi = i;
            e_ffv = 1;
            e_err++;
         end
      end
   endtask

   task automatic run(input int w, input int nr, input int s, input int m,
                      input int extra, input int abort_at);
      int   n, per, last_cyc, e_err, e_ffi, e_ffv;
      vec_t v;
      logic aborted, saw;
      mode = m;
      sel  = (w == 4) ? 1 : 0;
      q.delete();
      gen_run(w, nr, m, e_err, e_ffi, e_ffv);
      n = 8 + w + nr;
      per = s + 1;
      last_cyc = n * per;
      aborted = 0;
      @(negedge clk);
      if (sel == 0) start_a = 1; else start_b = 1;
      @(posedge clk);
      #1;
      start_a = 0;
      start_b = 0;
      v = q.pop_front();
      chk("vec0", {m_a, m_b, m_cin}, v);
      chk("busy_start", {m_busy, m_done, m_pass, m_ffv}, 4'b1000);
      chk("clr_err", m_err, 0);
      for (int cyc = 1; cyc <= last_cyc; cyc++) begin
         if (cyc == extra) begin
            if (sel == 0) start_a = 1; else start_b = 1;
         end
         if (cyc == abort_at) rst_n = 0;
         @(posedge clk);
         #1;
         start_a = 0;
         start_b = 0;
         if (cyc == abort_at) begin
            chk("abort_vec", {m_a, m_b, m_cin}, 0);
            chk("abort_flags", {m_busy, m_done, m_pass, m_ffv}, 0);
            chk("abort_err", {m_err, m_ffi}, 0);
            rst_n = 1;
            aborted = 1;
            break;
         end
         if (cyc < last_cyc) begin
            if (cyc % per == 0) begin
               if (q.size() == 0) begin
                  chk("q_underrun", 1, 0);
               end else begin
                  v = q.pop_front();
                  chk($sformatf("vec%0d", cyc / per), {m_a, m_b, m_cin}, v);
                  chk("run_busy", {m_busy, m_done}, 2'b10);
                  if (w == 4 && cyc / per == 7)
                     chk("w4_vec7", {m_a, m_b, m_cin}, {8'd8, 8'd8, 1'b0});
               end
            end
         end else begin
            chk("end_flags", {m_busy, m_done}, 2'b01);
            chk("end_pass", m_pass, (e_err == 0) ? 1 : 0);
            chk("end_err", m_err, e_err);
            chk("end_ffv", m_ffv, e_ffv);
            chk("end_ffi", m_ffi, e_ffi);
            chk("end_hold", {m_a, m_b, m_cin}, v);
            chk("q_empty", q.size(), 0);
         end
      end
      if (!aborted) begin
         @(posedge clk);
         #1;
         chk("done_pulse", {m_busy, m_done}, 2'b00);
         chk("hold_err", m_err, e_err);
      end else begin
         saw = 0;
         for (int i = 0; i < 2 * last_cyc; i++) begin
            @(posedge clk);
            #1;
            if (m_done || m_busy) saw = 1;
         end
         chk("abort_quiet", saw, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a", {a_a, a_b, a_cin, a_busy, a_done, a_pass, a_ffv}, 0);
      chk("rst_a_cnt", {a_err, a_ffi}, 0);
      chk("rst_b", {b_a, b_b, b_cin, b_busy, b_done, b_pass, b_ffv}, 0);
      rst_n = 1;
      repeat (2) @(posedge clk);

      run(8, 64, 1, 0, -1, -1);
      chk("good_pass", {m_pass, m_ffv}, 2'b10);

      run(8, 64, 1, 1, -1, -1);
      chk("cout0_ffi", m_ffi, 3);
      chk("cout0_min", (m_err >= 6) ? 1 : 0, 1);
      chk("cout0_pass", m_pass, 0);

      run(8, 64, 1, 2, -1, -1);
      chk("sum0_err", m_err, 80);
      chk("sum0_ffi", m_ffi, 0);

      run(8, 64, 1, 0, 50, -1);
      chk("restart_pass", m_pass, 1);

      run(8, 64, 1, 0, -1, 100);
      run(8, 64, 1, 0, -1, -1);
      chk("after_abort", {m_pass, m_err}, {1'b1, 16'd0});

      run(4, 16, 2, 0, -1, -1);
      chk("w4_pass", m_pass, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
